mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter for the PicoRV32 native memory bus (valid/ready, addr/wdata/wstrb/rdata, instr).
- Master 0 is the CPU; master 1 is a secondary requester such as a DMA or debug loader.
- The slave side drives the existing memory mux (BRAM/UART decode).
- Arbitration is round-robin; a grant is held for one whole transaction.
- A watchdog terminates any slave access that never returns ready.

Parameters:
TIMEOUT_CYCLES, 255, granted cycles without s_ready before forced termination (1..65535)
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on a timed-out access

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
m0_valid  in  1  master 0 request
m0_instr  in  1  master 0 instruction-fetch flag
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_wstrb  in  4  master 0 byte strobes (0 = read)
m0_ready  out  1  master 0 transfer complete
m0_rdata  out  32  master 0 read data
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  (same as m0_*, for master 1)
s_valid  out  1  slave request
s_instr  out  1  forwarded instr flag
s_addr  out  32  forwarded address
s_wdata  out  32  forwarded write data
s_wstrb  out  4  forwarded strobes
s_ready  in  1  slave complete
s_rdata  in  32  slave read data
grant  out  2  one-hot current owner (bit0 = m0); 0 when idle
timeout_err  out  1  one-cycle pulse on forced termination

Behaviour:
- States: IDLE, GNT0, GNT1. The state register, last-winner pointer `last` and watchdog counter `wd_cnt` are the only storage.
- Reset (sync, dominates all other inputs):
  - state=IDLE, last=1 (so m0 wins the first tie), wd_cnt=0.
  - All outputs 0: grant=0, s_valid=0, m*_ready=0, timeout_err=0.
  - Reset asserted mid-transaction abandons the transaction and drives no ready to either master.
- IDLE:
  - Only m0_valid set → GNT0. Only m1_valid set → GNT1.
  - Both set → grant goes to the master that is not `last`.
  - Neither set → stay in IDLE.
  - s_valid=0 throughout.
  - Arbitration costs exactly one cycle: a request first seen in IDLE reaches s_valid on the next cycle.
- GNTn:
  - s_* mirrors master n combinationally: s_valid=mn_valid; instr/addr/wdata/wstrb are forwarded.
  - mn_ready=s_ready and mn_rdata=s_rdata (combinational pass-through).
  - The non-granted master sees ready=0 and rdata=0.
  - grant is one-hot n.
- Completion: s_ready=1 while in GNTn → last=n, wd_cnt=0, next state IDLE.
  - Back-to-back requests from the same master therefore take ≥1 idle cycle.
  - With both masters requesting continuously, grants alternate 0,1,0,1.
- Abandon: mn_valid drops before s_ready (protocol violation) → return to IDLE, last unchanged, no error.
- Watchdog:
  - wd_cnt increments each GNTn cycle with s_ready=0.
  - When wd_cnt==TIMEOUT_CYCLES-1 and s_ready=0, in that cycle:
    - mn_ready=1, mn_rdata=ERR_RDATA;
    - s_valid forced to 0;
    - timeout_err=1.
  - Next state: IDLE, last=n, wd_cnt=0.
  - If s_ready and timeout coincide, the normal completion wins and there is no error pulse.
- Counter width is clog2(TIMEOUT_CYCLES+1); it never wraps because it clears on every exit from GNTn.
- s_ready arriving while in IDLE is ignored.

Decomposition:
- Shared package `soc_bus_pkg`:
  - state encoding constants (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2);
  - bus widths (ADDR_W=32, DATA_W=32, STRB_W=4);
  - default ERR_RDATA.
- One natural sub-module: `bus_watchdog` (counter + terminal-count compare, with clear/enable inputs), reused later for the UART-busy timeout.
- Everything else stays in a single module.

Test Plan:
1. Reset held 3 cycles while m0_valid=1 → grant=0, s_valid=0, m0_ready=0; first cycle after release → IDLE, then grant=2'b01 on the next cycle.
2. m0 reads 0x0000_0100, slave returns 32'h1234_5678 with s_ready two cycles after s_valid → m0_rdata=32'h1234_5678 and m0_ready=1 in that same cycle; next cycle grant=0.
3. m0 and m1 both hold valid for 6 transactions, slave ready in 1 cycle → grant sequence 01,10,01,10,01,10 separated by idle cycles; m1 never waits more than one transaction.
4. m1 writes wstrb=4'b0011, wdata=32'hAABB_CCDD to 0x0200_0000 → s_wstrb=4'b0011, s_wdata and s_addr match exactly; m0_ready stays 0.
5. TIMEOUT_CYCLES=8, slave never readies on an m0 read → on the 8th granted cycle: m0_ready=1, m0_rdata=32'hDEAD_BEEF, timeout_err pulses once, s_valid=0; returns to IDLE.
6. TIMEOUT_CYCLES=8, s_ready on the 8th cycle → normal completion, timeout_err=0. Separately, m1_valid dropped mid-grant → IDLE next cycle, and a pending m0 is then granted.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared state encoding, widths and defaults for the native memory bus
package soc_bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: cycle counter that flags terminal count LIMIT-1; clear wins over enable
module bus_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk)
        r_cnt <= (reset || i_clr) ? '0 : i_en ? r_cnt + CW'(1) : r_cnt;
    assign o_tc = r_cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter for the PicoRV32 native bus with a slave watchdog
module mem_bus_arbiter
    import soc_bus_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        grant,
    output logic              timeout_err
);
    state_t r_state;
    logic   r_last;
    logic   w_g0, w_g1, w_gv, w_tc, w_to;
    // Reset masks every output so an interrupted transfer never completes
    assign w_g0 = !reset && r_state == GNT0;
    assign w_g1 = !reset && r_state == GNT1;
    assign w_gv = (w_g0 && m0_valid) || (w_g1 && m1_valid);
    assign w_to = w_gv && !s_ready && w_tc;
    assign grant       = {w_g1, w_g0};
    assign timeout_err = w_to;
    assign s_valid  = w_gv && !w_to;
    assign s_instr  = w_g1 ? m1_instr : w_g0 && m0_instr;
    assign s_addr   = w_g1 ? m1_addr  : w_g0 ? m0_addr  : '0;
    assign s_wdata  = w_g1 ? m1_wdata : w_g0 ? m0_wdata : '0;
    assign s_wstrb  = w_g1 ? m1_wstrb : w_g0 ? m0_wstrb : '0;
    assign m0_ready = w_g0 && (s_ready || w_to);
    assign m1_ready = w_g1 && (s_ready || w_to);
    assign m0_rdata = !w_g0 ? '0 : w_to ? ERR_RDATA : s_rdata;
    assign m1_rdata = !w_g1 ? '0 : w_to ? ERR_RDATA : s_rdata;
    bus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk   (clk),
        .reset (reset),
        .i_clr (!(w_g0 || w_g1) || s_ready || !w_gv || w_to),
        .i_en  ((w_g0 || w_g1) && !s_ready),
        .o_tc  (w_tc)
    );
    // last=1 after reset so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else if (r_state == IDLE) begin
            r_state <= (m0_valid && (!m1_valid || r_last)) ? GNT0 : m1_valid ? GNT1 : IDLE;
        end else if (s_ready || w_to || !w_gv) begin
            r_state <= IDLE;
            if (s_ready || w_to) r_last <= w_g1;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed steps with a completion scoreboard against mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    typedef struct {bit m; logic [31:0] rdata; bit to;} exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int sl_lat = -1;
    int sl_cnt = 0;
    logic [31:0] sl_data = 32'h0;
    int n;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Slave model keyed on the registered grant: ready after sl_lat granted cycles, never if negative
    initial begin
        s_ready = 1'b0;
        s_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            s_ready = grant != 2'b00 && sl_lat >= 0 && sl_cnt == sl_lat;
            sl_cnt  = grant != 2'b00 ? sl_cnt + 1 : 0;
            s_rdata = sl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completion it consumed
    task automatic wait_done(input int bound, output int cyc);
        exp_t e;
        bit hit;
        cyc = 0;
        hit = 0;
        while (!hit && cyc <= bound) begin
            if (m0_ready || m1_ready) begin
                hit = 1;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ready_vec", 32'({m1_ready, m0_ready}), e.m ? 32'd2 : 32'd1);
                    chk("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                    chk("other_rdata", e.m ? m0_rdata : m1_rdata, 32'h0);
                    chk("timeout_err", 32'(timeout_err), 32'(e.to));
                    if (e.to) chk("s_valid_on_timeout", 32'(s_valid), 32'd0);
                end
                @(negedge clk);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("ready_within_bound", 32'(hit), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        {m0_valid, m0_instr, m1_valid, m1_instr} = 4'b1000;
        m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_1111; m0_wstrb = 4'b0000;
        m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'b0000;
        sl_lat = 2; sl_data = 32'h1234_5678;
        // 1: reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_s_valid", 32'(s_valid), 32'd0);
            chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        end
        reset = 1'b0;
        #1 chk("post_release_idle", 32'(grant), 32'd0);
        @(negedge clk);
        chk("first_grant", 32'(grant), 32'd1);
        // 2: m0 read, slave answers two cycles after s_valid
        chk("rd_s_valid", 32'(s_valid), 32'd1);
        chk("rd_s_addr", s_addr, 32'h0000_0100);
        chk("rd_s_wstrb", 32'(s_wstrb), 32'd0);
        sb.push_back('{m: 1'b0, rdata: 32'h1234_5678, to: 1'b0});
        wait_done(6, n);
        chk("rd_latency", 32'(n), 32'd2);
        chk("rd_idle_after", 32'(grant), 32'd0);
        m0_valid = 1'b0;
        // 3: both masters continuous after a fresh reset: strict alternation from m0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0400;
        m1_valid = 1'b1; m1_addr = 32'h0000_0800;
        sl_lat = 0; sl_data = 32'hCAFE_0000;
        for (int i = 0; i < 6; i++) sb.push_back('{m: i[0], rdata: 32'hCAFE_0000, to: 1'b0});
        for (int i = 0; i < 6; i++) begin
            wait_done(2, n);
            chk("rr_wait", 32'(n), 32'd1);
            chk("rr_idle_gap", 32'(grant), 32'd0);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        // 4: m1 partial write forwarded exactly
        m1_valid = 1'b1; m1_instr = 1'b1; m1_addr = 32'h0200_0000;
        m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
        m0_addr = 32'h0000_0FF0; m0_wdata = 32'h5555_5555; m0_wstrb = 4'b1111;
        sl_lat = 1; sl_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk("wr_grant", 32'(grant), 32'd2);
        chk("wr_s_wstrb", 32'(s_wstrb), 32'h3);
        chk("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
        chk("wr_s_addr", s_addr, 32'h0200_0000);
        chk("wr_s_instr", 32'(s_instr), 32'd1);
        chk("wr_m0_ready", 32'(m0_ready), 32'd0);
        chk("wr_m0_rdata", m0_rdata, 32'h0);
        sb.push_back('{m: 1'b1, rdata: 32'h0BAD_F00D, to: 1'b0});
        wait_done(5, n);
        chk("wr_m0_ready_after", 32'(m0_ready), 32'd0);
        m1_valid = 1'b0; m1_instr = 1'b0;
        // 5: slave never answers: watchdog terminates on the 8th granted cycle
        m0_valid = 1'b1; m0_addr = 32'h0000_0300; m0_wstrb = 4'b0000;
        sl_lat = -1;
        sb.push_back('{m: 1'b0, rdata: 32'hDEAD_BEEF, to: 1'b1});
        wait_done(12, n);
        chk("to_cycle", 32'(n), 32'd8);
        chk("to_idle_after", 32'(grant), 32'd0);
        chk("to_single_pulse", 32'(timeout_err), 32'd0);
        m0_valid = 1'b0;
        // 6a: ready on the terminal cycle completes normally
        @(negedge clk);
        m0_valid = 1'b1;
        sl_lat = 7; sl_data = 32'h7777_0008;
        sb.push_back('{m: 1'b0, rdata: 32'h7777_0008, to: 1'b0});
        wait_done(12, n);
        chk("late_ready_cycle", 32'(n), 32'd8);
        m0_valid = 1'b0;
        // 6b: m1 abandons mid-grant, then a pending m0 is served
        m1_valid = 1'b1;
        sl_lat = -1;
        @(negedge clk);
        chk("ab_grant", 32'(grant), 32'd2);
        m1_valid = 1'b0;
        m0_valid = 1'b1;
        @(negedge clk);
        chk("ab_idle", 32'(grant), 32'd0);
        chk("ab_m1_ready", 32'(m1_ready), 32'd0);
        chk("ab_no_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("ab_m0_granted", 32'(grant), 32'd1);
        m0_valid = 1'b0;
        @(negedge clk);
        chk("ab_m0_idle", 32'(grant), 32'd0);
        // Reset arriving with s_ready already high suppresses the handshake
        m0_valid = 1'b1;
        sl_lat = 1;
        @(negedge clk);
        chk("mid_grant", 32'(grant), 32'd1);
        @(negedge clk);
        chk("mid_ready_pre", 32'(m0_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(m0_ready), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(grant), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
